// File: rtl/hq_asm_pkg.sv
// Shared types and defaults for the hq_fifo message assembler.
// The optional partial-message timeout is enabled by defining HQ_ASM_TIMEOUT_EN.
package hq_asm_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_e;

  // One decoded action per cycle; the FSM and both counters key off this.
  typedef enum logic [2:0] {
    ACT_NONE,
    ACT_START,
    ACT_STORE,
    ACT_EMIT,
    ACT_RESTART,
    ACT_BREAK,
    ACT_DROP,
    ACT_TIMEOUT
  } act_e;

  localparam int DEF_WORD_W         = 64;
  localparam int DEF_MSG_WORDS      = 4;
  localparam int DEF_CNT_W          = 64;
  localparam int DEF_TIMEOUT_CYCLES = 1024;

  // Index width, kept at least one bit so single-word messages still have a port.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int msg_w(input int word_w, input int n);
    return word_w * n;
  endfunction

endpackage

// File: rtl/hq_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module hq_sat_counter #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] value
);

  logic [WIDTH-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != {WIDTH{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign value = cnt_q;

endmodule

// File: rtl/hq_msg_assembler.sv
// Gathers in-order MMIO words into one wide message and strobes it to hq_fifo.
// Define HQ_ASM_TIMEOUT_EN to discard partials left idle for TIMEOUT_CYCLES.
module hq_msg_assembler
  import hq_asm_pkg::*;
#(
  parameter int WORD_W         = DEF_WORD_W,
  parameter int MSG_WORDS      = DEF_MSG_WORDS,
  parameter int CNT_W          = DEF_CNT_W,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  localparam int IDX_W         = idx_w(MSG_WORDS),
  localparam int MSG_W         = msg_w(WORD_W, MSG_WORDS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mmio_valid,
  input  logic [IDX_W-1:0]  mmio_idx,
  input  logic [WORD_W-1:0] mmio_data,
  output logic [MSG_W-1:0]  wr_msg,
  output logic              wr_valid,
  output logic              busy,
  output logic [CNT_W-1:0]  msg_count,
  output logic [CNT_W-1:0]  err_count
);

  localparam int BUF_N = (MSG_WORDS > 1) ? MSG_WORDS - 1 : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MSG_WORDS - 1);

  state_e                  state_q;
  logic [IDX_W-1:0]        expect_q;
  logic [WORD_W-1:0]       buf_q [BUF_N];
  logic [BUF_N*WORD_W-1:0] buf_flat;
  logic [MSG_W-1:0]        emit_msg;
  logic [MSG_W-1:0]        wr_msg_q;
  logic                    wr_valid_q;
  logic                    to_expire;
  act_e                    act;

  for (genvar gi = 0; gi < BUF_N; gi++) begin : g_flat
    assign buf_flat[gi*WORD_W +: WORD_W] = buf_q[gi];
  end

  if (MSG_WORDS > 1) begin : g_multi
    assign emit_msg = {mmio_data, buf_flat};
  end else begin : g_single
    logic unused_buf;
    assign unused_buf = ^buf_flat;
    assign emit_msg   = mmio_data;
  end

`ifdef HQ_ASM_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_q;

  // A word in the expiry cycle takes priority, so only idle cycles can expire.
  assign to_expire = (state_q == COLLECT) && !mmio_valid &&
                     (to_q == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_q <= '0;
    end else if ((state_q == COLLECT) && !mmio_valid && !to_expire) begin
      to_q <= to_q + 1'b1;
    end else begin
      to_q <= '0;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES > 0);
  assign to_expire      = 1'b0;
`endif

  always_comb begin
    act = ACT_NONE;
    if (mmio_valid) begin
      if (state_q == IDLE) begin
        if (mmio_idx == '0) act = (MSG_WORDS == 1) ? ACT_EMIT : ACT_START;
        else                act = ACT_DROP;
      end else if (mmio_idx == expect_q) begin
        act = (expect_q == LAST_IDX) ? ACT_EMIT : ACT_STORE;
      end else if (mmio_idx == '0) begin
        act = ACT_RESTART;
      end else begin
        act = ACT_BREAK;
      end
    end else if (to_expire) begin
      act = ACT_TIMEOUT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      expect_q   <= '0;
      wr_valid_q <= 1'b0;
      wr_msg_q   <= '0;
      for (int i = 0; i < BUF_N; i++) buf_q[i] <= '0;
    end else begin
      wr_valid_q <= 1'b0;
      case (act)
        ACT_START, ACT_RESTART: begin
          buf_q[0] <= mmio_data;
          expect_q <= IDX_W'(1);
          state_q  <= COLLECT;
        end
        ACT_STORE: begin
          for (int i = 0; i < BUF_N; i++) begin
            if (expect_q == IDX_W'(i)) buf_q[i] <= mmio_data;
          end
          expect_q <= expect_q + 1'b1;
        end
        ACT_EMIT: begin
          wr_msg_q   <= emit_msg;
          wr_valid_q <= 1'b1;
          expect_q   <= '0;
          state_q    <= IDLE;
        end
        ACT_BREAK, ACT_TIMEOUT: begin
          expect_q <= '0;
          state_q  <= IDLE;
        end
        default: ;
      endcase
    end
  end

  hq_sat_counter #(.WIDTH(CNT_W)) u_msg_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (act == ACT_EMIT),
    .value (msg_count)
  );

  hq_sat_counter #(.WIDTH(CNT_W)) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   ((act == ACT_DROP) || (act == ACT_RESTART) ||
            (act == ACT_BREAK) || (act == ACT_TIMEOUT)),
    .value (err_count)
  );

  assign wr_msg   = wr_msg_q;
  assign wr_valid = wr_valid_q;
  assign busy     = (state_q == COLLECT);

endmodule
